// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache with line refill/writeback FSM
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] access_cnt,
    output logic [31:0] miss_cnt
);
    localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE     = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t                    state;
    logic [31:0]               data_mem [SET_SIZE][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0]   tag_mem  [SET_SIZE];
    logic [SET_SIZE-1:0]       valid;
    logic [SET_SIZE-1:0]       dirty;

    logic [TAG_ADDR_LEN-1:0]   req_tag;
    logic [SET_ADDR_LEN-1:0]   req_set;
    logic [LINE_ADDR_LEN-1:0]  req_word;
    logic [TAG_ADDR_LEN-1:0]   miss_tag;
    logic [TAG_ADDR_LEN-1:0]   victim_tag;
    logic [SET_ADDR_LEN-1:0]   miss_set;
    logic [LINE_ADDR_LEN-1:0]  beat;
    logic                      req;
    logic                      hit;
    logic                      last_beat;
    logic                      unused_addr_bits;

    assign req_tag          = addr[31 -: TAG_ADDR_LEN];
    assign req_set          = addr[LINE_ADDR_LEN + 2 +: SET_ADDR_LEN];
    assign req_word         = addr[2 +: LINE_ADDR_LEN];
    assign unused_addr_bits = ^addr[1:0];

    assign req       = rd_req | wr_req;
    assign hit       = valid[req_set] && (tag_mem[req_set] == req_tag);
    assign miss      = (state != IDLE) || (req && !hit);
    assign last_beat = &beat;
    assign rd_data   = (rd_req && !miss) ? data_mem[req_set][req_word] : 32'd0;

    // Memory port is decoded from registered state so it holds steady for a whole beat.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_tag, miss_set, beat, 2'b00};
                mem_wdata = data_mem[miss_set][beat];
            end
            FILL: begin
                mem_req   = 1'b1;
                mem_addr  = {miss_tag, miss_set, beat, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            beat       <= '0;
            miss_set   <= '0;
            miss_tag   <= '0;
            victim_tag <= '0;
            access_cnt <= 32'd0;
            miss_cnt   <= 32'd0;
        end else begin
            if (req && !miss)
                access_cnt <= access_cnt + 32'd1;
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_set   <= req_set;
                        miss_tag   <= req_tag;
                        victim_tag <= tag_mem[req_set];
                        beat       <= '0;
                        miss_cnt   <= miss_cnt + 32'd1;
                        valid[req_set] <= 1'b0;
                        state      <= (valid[req_set] && dirty[req_set]) ? WB : FILL;
                    end else if (wr_req && hit) begin
                        dirty[req_set] <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            dirty[miss_set] <= 1'b0;
                            state           <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[miss_set] <= 1'b1;
                            dirty[miss_set] <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays are not reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_req && hit)
            data_mem[req_set][req_word] <= wr_data;
        if (state == FILL && mem_ack) begin
            data_mem[miss_set][beat] <= mem_rdata;
            if (last_beat)
                tag_mem[miss_set] <= miss_tag;
        end
    end
endmodule
